// File: rtl/run_controller.sv
// run_controller: run/reset sequencer for the single-cycle core.
// Drives the core's active-low reset and clock enable, counts executed cycles
// and detects program halt (PC unchanged for HALT_REPEAT consecutive cycles).
// Modes (latched at start): 0/3 fixed budget, 1 run-to-halt with timeout,
// 2 single-step (one core cycle per cycle step_req is high).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               launch a run (accepted only when not busy)
//   run_mode            run mode, latched at start
//   cycle_budget        run length / timeout (0 = unlimited in modes 1/2)
//   step_req            mode 2 step request
//   pc_in               core program counter
//   core_rst_n          active-low core reset
//   core_clk_en         core advance enable
//   busy                high during RESET/RUN
//   done/halted/timeout run completion flags
//   cycle_count         enabled RUN cycles executed (saturating)
//   last_pc             pc_in at the last enabled RUN cycle
module run_controller #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned HALT_REPEAT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       run_mode,
  input  logic [CNT_W-1:0] cycle_budget,
  input  logic             step_req,
  input  logic [PC_W-1:0]  pc_in,
  output logic             core_rst_n,
  output logic             core_clk_en,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  last_pc
);

  localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);
  localparam int unsigned RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t           state, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             first_q, first_d;

  logic             core_rst_n_d, core_clk_en_d, busy_d, done_d, halted_d, timeout_d;
  logic [CNT_W-1:0] cycle_count_d;
  logic [PC_W-1:0]  last_pc_d;

  logic             stop_mode_c;   // modes 0/3: budget ends the run normally
  logic             halt_mode_c;   // modes 1/2: halt detect active, budget is a timeout
  logic [REP_W-1:0] rep_nx_c;
  logic             halt_hit_c;
  logic             budget_hit_c;

  assign stop_mode_c = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign halt_mode_c = (mode_q == 2'd1) || (mode_q == 2'd2);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 2'd0;
      budget_q    <= '0;
      rcnt_q      <= '0;
      rep_q       <= '0;
      first_q     <= 1'b1;
      core_rst_n  <= 1'b0;
      core_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      last_pc     <= '0;
    end else begin
      state       <= state_d;
      mode_q      <= mode_d;
      budget_q    <= budget_d;
      rcnt_q      <= rcnt_d;
      rep_q       <= rep_d;
      first_q     <= first_d;
      core_rst_n  <= core_rst_n_d;
      core_clk_en <= core_clk_en_d;
      busy        <= busy_d;
      done        <= done_d;
      halted      <= halted_d;
      timeout     <= timeout_d;
      cycle_count <= cycle_count_d;
      last_pc     <= last_pc_d;
    end
  end

  // Per-enabled-cycle bookkeeping: repeat tracking and completion conditions
  always_comb begin
    rep_nx_c = '0;
    if (!first_q && (pc_in == last_pc)) begin
      rep_nx_c = (rep_q == REP_W'(HALT_REPEAT)) ? rep_q : rep_q + REP_W'(1);
    end
    halt_hit_c   = halt_mode_c && (rep_nx_c == REP_W'(HALT_REPEAT));
    // Zero budget means unlimited in the halt-detect modes
    budget_hit_c = (cycle_count == budget_q - CNT_W'(1)) &&
                   !(halt_mode_c && (budget_q == '0));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    mode_d        = mode_q;
    budget_d      = budget_q;
    rcnt_d        = rcnt_q;
    rep_d         = rep_q;
    first_d       = first_q;
    core_rst_n_d  = core_rst_n;
    core_clk_en_d = core_clk_en;
    busy_d        = busy;
    done_d        = done;
    halted_d      = halted;
    timeout_d     = timeout;
    cycle_count_d = cycle_count;
    last_pc_d     = last_pc;

    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        core_clk_en_d = 1'b0;
        busy_d        = 1'b0;
        if (start) begin
          state_d       = S_RESET;
          mode_d        = run_mode;
          budget_d      = cycle_budget;
          rcnt_d        = '0;
          rep_d         = '0;
          first_d       = 1'b1;
          core_rst_n_d  = 1'b0;
          core_clk_en_d = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          halted_d      = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
        end
      end

      S_RESET: begin
        if (rcnt_q == RC_W'(RESET_CYCLES - 1)) begin
          core_rst_n_d = 1'b1;
          if (stop_mode_c && (budget_q == '0)) begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            core_clk_en_d = 1'b0;
            busy_d        = 1'b0;
          end else begin
            state_d       = S_RUN;
            core_clk_en_d = (mode_q == 2'd2) ? step_req : 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end

      S_RUN: begin
        core_clk_en_d = (mode_q == 2'd2) ? step_req : 1'b1;
        if (core_clk_en) begin
          cycle_count_d = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
          last_pc_d     = pc_in;
          first_d       = 1'b0;
          rep_d         = rep_nx_c;
          // Halt takes priority over a coincident budget hit
          if (halt_hit_c) begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            halted_d      = 1'b1;
            core_clk_en_d = 1'b0;
            busy_d        = 1'b0;
          end else if (budget_hit_c) begin
            core_clk_en_d = 1'b0;
            busy_d        = 1'b0;
            if (stop_mode_c) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_TIMEOUT;
              timeout_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
